// File: rtl/y86_pkg.sv
// Shared Y86 execute-stage constants: instruction codes, ALU/condition function
// codes, CC bit positions and the condition evaluator used by the issue logic.
`default_nettype none

package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_SUB = 4'h1;
  localparam logic [3:0] FN_AND = 4'h2;
  localparam logic [3:0] FN_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic lt;
    logic res;
    lt  = cc[CC_SF] ^ cc[CC_OF];
    res = 1'b0;
    case (fn)
      C_YES:   res = 1'b1;
      C_LE:    res = lt | cc[CC_ZF];
      C_L:     res = lt;
      C_E:     res = cc[CC_ZF];
      C_NE:    res = ~cc[CC_ZF];
      C_GE:    res = ~lt;
      C_G:     res = ~lt & ~cc[CC_ZF];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// Combinational ALU: result = b op a, with {ZF,SF,OF} flags derived from the result.
`default_nettype none

module alu_core
  import y86_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  logic sa, sb, sr;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = b + a;
      ALU_SUB: result = b - a;
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = '0;
    endcase
  end

  assign sa = a[WIDTH-1];
  assign sb = b[WIDTH-1];
  assign sr = result[WIDTH-1];

  always_comb begin
    flags        = 3'b000;
    flags[CC_ZF] = (result == '0);
    flags[CC_SF] = sr;
    case (op)
      ALU_ADD: flags[CC_OF] = (sa == sb) & (sr != sb);
      // b - a overflows only when the operands differ in sign and the result leaves b's sign
      ALU_SUB: flags[CC_OF] = (sa != sb) & (sr != sb);
      default: flags[CC_OF] = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_alu_issue.sv
// Execute-stage issue: operand muxing into alu_core, CC register, condition
// evaluation and a single valid/ready output register. Option: CC_INHIBIT_EN.
`default_nettype none

module ex_alu_issue
  import y86_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
`ifdef CC_INHIBIT_EN
  input  logic             set_cc_inhibit,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic [WIDTH-1:0] val_c,
  input  logic [3:0]       dst_e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val_e,
  output logic             out_cnd,
  output logic [3:0]       out_dst_e,
  output logic [2:0]       cc
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_val_e_q, out_val_e_d;
  logic             out_cnd_q,   out_cnd_d;
  logic [3:0]       out_dst_e_q, out_dst_e_d;
  logic [2:0]       cc_q,        cc_d;

  logic             accept;
  logic             is_opq;
  logic             cc_inhibit;
  logic             cnd;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  alu_op_e          alu_op;
  logic [2:0]       alu_flags;

`ifdef CC_INHIBIT_EN
  assign cc_inhibit = set_cc_inhibit;
`else
  assign cc_inhibit = 1'b0;
`endif

  assign in_ready = (~out_valid_q | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;
  assign is_opq   = (icode == I_OPQ) && (ifun[3:2] == 2'b00);

  // Every non-ALU result is expressed as an add/sub so one ALU instance serves all icodes.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    case (icode)
      I_HALT, I_NOP, I_JXX: begin
        alu_a = '0;
        alu_b = '0;
      end
      I_CMOV:  alu_a = val_a;
      I_IRMOV: alu_a = val_c;
      I_RMMOV, I_MRMOV: begin
        alu_a = val_c;
        alu_b = val_b;
      end
      I_OPQ: begin
        if (is_opq) begin
          alu_a = val_a;
          alu_b = val_b;
        end
        case (ifun)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_XOR:  alu_op = ALU_XOR;
          default: alu_op = ALU_ADD;
        endcase
      end
      I_CALL, I_PUSH: begin
        alu_a  = STEP;
        alu_b  = val_b;
        alu_op = ALU_SUB;
      end
      I_RET, I_POP: begin
        alu_a = STEP;
        alu_b = val_b;
      end
      default: begin
        alu_a = '0;
        alu_b = '0;
      end
    endcase
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .flags  (alu_flags)
  );

  // Condition reads the registered CC, i.e. the value before this edge's update.
  assign cnd = ((icode == I_JXX) || (icode == I_CMOV)) ? cond_eval(ifun, cc_q) : 1'b0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_val_e_d = out_val_e_q;
    out_cnd_d   = out_cnd_q;
    out_dst_e_d = out_dst_e_q;
    cc_d        = cc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_val_e_d = alu_res;
      out_cnd_d   = cnd;
      out_dst_e_d = ((icode == I_CMOV) && !cnd) ? RNONE : dst_e;
      if (is_opq && !cc_inhibit) begin
        cc_d = alu_flags;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_val_e_q <= '0;
      out_cnd_q   <= 1'b0;
      out_dst_e_q <= RNONE;
      cc_q        <= CC_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      out_val_e_q <= out_val_e_d;
      out_cnd_q   <= out_cnd_d;
      out_dst_e_q <= out_dst_e_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_val_e = out_val_e_q;
  assign out_cnd   = out_cnd_q;
  assign out_dst_e = out_dst_e_q;
  assign cc        = cc_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_alu_issue.sv
// Bench for ex_alu_issue: directed scenarios then random traffic against a behavioural model.
`default_nettype none

module tb_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, dst_e;
  logic [31:0] val_a, val_b, val_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_val_e;
  logic        out_cnd;
  logic [3:0]  out_dst_e;
  logic [2:0]  cc;
`ifdef CC_INHIBIT_EN
  logic        set_cc_inhibit;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: what the output register and CC should hold.
  logic        m_valid;
  logic [31:0] m_vale;
  logic        m_cnd;
  logic [3:0]  m_dst;
  logic [2:0]  m_cc;

  always #5 clk = ~clk;

  ex_alu_issue #(.WIDTH(32), .STACK_STEP(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
`ifdef CC_INHIBIT_EN
    .set_cc_inhibit (set_cc_inhibit),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .val_a     (val_a),
    .val_b     (val_b),
    .val_c     (val_c),
    .dst_e     (dst_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val_e (out_val_e),
    .out_cnd   (out_cnd),
    .out_dst_e (out_dst_e),
    .cc        (cc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    case (ic)
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5: return b + c;
      4'h6: case (fn)
              4'h0: return b + a;
              4'h1: return b - a;
              4'h2: return b & a;
              4'h3: return b ^ a;
              default: return 32'h0;
            endcase
      4'h8, 4'hA: return b - 32'd8;
      4'h9, 4'hB: return b + 32'd8;
      default: return 32'h0;
    endcase
  endfunction

  // Flags from true signed arithmetic: overflow iff the exact result does not fit in 32 bits.
  function automatic logic [2:0] ref_flags(input logic [3:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    longint sa, sb, exact, trunc;
    logic of;
    r     = ref_vale(4'h6, fn, a, b, 32'h0);
    sa    = $signed(a);
    sb    = $signed(b);
    trunc = $signed(r);
    of    = 1'b0;
    if (fn == 4'h0) begin
      exact = sb + sa;
      of    = (exact != trunc);
    end else if (fn == 4'h1) begin
      exact = sb - sa;
      of    = (exact != trunc);
    end
    return {(r == 32'h0), r[31], of};
  endfunction

  function automatic logic ref_cond(input logic [3:0] fn, input logic [2:0] c);
    logic zf, lt;
    zf = c[2];
    lt = (c[1] != c[0]);
    case (fn)
      4'h0: return 1'b1;
      4'h1: return lt || zf;
      4'h2: return lt;
      4'h3: return zf;
      4'h4: return !zf;
      4'h5: return !lt;
      4'h6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_vale  = 32'h0;
    m_cnd   = 1'b0;
    m_dst   = 4'hF;
    m_cc    = 3'b100;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ":out_valid"}, {31'h0, out_valid}, {31'h0, m_valid});
    chk({where, ":cc"}, {29'h0, cc}, {29'h0, m_cc});
    if (m_valid) begin
      chk({where, ":out_val_e"}, out_val_e, m_vale);
      chk({where, ":out_cnd"}, {31'h0, out_cnd}, {31'h0, m_cnd});
      chk({where, ":out_dst_e"}, {28'h0, out_dst_e}, {28'h0, m_dst});
    end
  endtask

  // One clock: called at a negedge, drives inputs, checks in_ready, clocks, checks outputs.
  task automatic step(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [3:0] dst, input logic iv, input logic ordy,
                      input logic fl, input logic inh);
    logic rdy, acc, inh_eff, cnd;
    icode = ic; ifun = fn; val_a = a; val_b = b; val_c = c; dst_e = dst;
    in_valid = iv; out_ready = ordy; flush = fl;
`ifdef CC_INHIBIT_EN
    set_cc_inhibit = inh;
    inh_eff = inh;
`else
    inh_eff = 1'b0 & inh;
`endif
    #1;
    rdy = (!m_valid || ordy) && !fl;
    chk({tag, ":in_ready"}, {31'h0, in_ready}, {31'h0, rdy});
    acc = iv && rdy;
    if (fl) begin
      m_valid = 1'b0;
    end else if (acc) begin
      cnd     = (ic == 4'h7 || ic == 4'h2) ? ref_cond(fn, m_cc) : 1'b0;
      m_valid = 1'b1;
      m_vale  = ref_vale(ic, fn, a, b, c);
      m_cnd   = cnd;
      m_dst   = (ic == 4'h2 && !cnd) ? 4'hF : dst;
      if (ic == 4'h6 && fn < 4'h4 && !inh_eff) m_cc = ref_flags(fn, a, b);
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    logic [2:0]  cc_before;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h1; ifun = 4'h0; val_a = 32'h0; val_b = 32'h0; val_c = 32'h0; dst_e = 4'h0;
`ifdef CC_INHIBIT_EN
    set_cc_inhibit = 1'b0;
`endif
    model_reset();
    #12;
    chk("reset:out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset:out_val_e", out_val_e, 32'h0);
    chk("reset:out_cnd", {31'h0, out_cnd}, 32'h0);
    chk("reset:out_dst_e", {28'h0, out_dst_e}, 32'hF);
    chk("reset:cc", {29'h0, cc}, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;

    step("xor", 4'h6, 4'h3, 32'h0000000B, 32'h00000004, 32'h0, 4'h1, 1, 1, 0, 0);
    chk("xor:val_e_const", out_val_e, 32'h0000000F);
    chk("xor:cc_const", {29'h0, cc}, 32'h0);

    step("sub", 4'h6, 4'h1, 32'h1, 32'h80000000, 32'h0, 4'h2, 1, 1, 0, 0);
    chk("sub:val_e_const", out_val_e, 32'h7FFFFFFF);
    chk("sub:cc_const", {29'h0, cc}, 32'h1);
    step("jl", 4'h7, 4'h2, 32'h0, 32'h0, 32'h40, 4'hF, 1, 1, 0, 0);
    chk("jl:cnd_const", {31'h0, out_cnd}, 32'h1);

    step("xorz", 4'h6, 4'h3, 32'h9, 32'h9, 32'h0, 4'h4, 1, 1, 0, 0);
    chk("xorz:cc_const", {29'h0, cc}, 32'h4);
    step("cmovne", 4'h2, 4'h4, 32'h55, 32'h0, 32'h0, 4'h3, 1, 1, 0, 0);
    chk("cmovne:cnd_const", {31'h0, out_cnd}, 32'h0);
    chk("cmovne:dst_const", {28'h0, out_dst_e}, 32'hF);

    step("irmov", 4'h3, 4'h0, 32'h0, 32'h0, 32'h1234, 4'h5, 1, 0, 0, 0);
    held = out_val_e;
    for (int i = 0; i < 3; i++) begin
      step("stall", 4'h6, 4'h0, 32'h7, 32'h8, 32'h0, 4'h6, 1, 0, 0, 0);
      chk("stall:held_val", out_val_e, held);
    end
    step("release", 4'h6, 4'h0, 32'h7, 32'h8, 32'h0, 4'h6, 1, 1, 0, 0);
    chk("release:val_const", out_val_e, 32'hF);

    step("push", 4'hA, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 1, 1, 0, 0);
    chk("push:val_const", out_val_e, 32'hF8);
    cc_before = cc;
    step("flush", 4'h6, 4'h0, 32'h80000000, 32'h80000000, 32'h0, 4'h1, 1, 1, 1, 0);
    chk("flush:valid_const", {31'h0, out_valid}, 32'h0);
    chk("flush:cc_hold", {29'h0, cc}, {29'h0, cc_before});

`ifdef CC_INHIBIT_EN
    cc_before = cc;
    step("inhibit", 4'h6, 4'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 4'h2, 1, 1, 0, 1);
    chk("inhibit:val_const", out_val_e, 32'h0);
    chk("inhibit:cc_hold", {29'h0, cc}, {29'h0, cc_before});
`endif

    // Asynchronous reset while a result is stalled in the output register.
    step("pre_rst", 4'h5, 4'h0, 32'h0, 32'h10, 32'h20, 4'h7, 1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst:out_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst:cc", {29'h0, cc}, 32'h4);
    chk("async_rst:dst", {28'h0, out_dst_e}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 500; i++) begin
      logic [3:0] ic, fn;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)      ic = 4'h6;
      else if (sel < 6) ic = 4'h7;
      else if (sel < 7) ic = 4'h2;
      else              ic = 4'($urandom_range(0, 15));
      fn = (sel < 4) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 8));
      step("rand", ic, fn, rnd_op(), rnd_op(), rnd_op(), 4'($urandom_range(0, 14)),
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_alu_issue.md
Name: ex_alu_issue

Overview:
Execute-stage front end that drives operands into the combinational ALU and consumes its result and flags. It sits between the decode-stage register (valid/ready upstream) and the memory stage (valid/ready downstream). It has one registered output stage, holds the condition-code (CC) register, and evaluates branch/cmov conditions.

Parameters:
WIDTH, 32, datapath width of val_a/val_b/val_c/val_e
STACK_STEP, 8, rsp adjustment for call/push/ret/pop

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous bubble request from pipeline control
in_valid  in  1  decode has an instruction
in_ready  out  1  block can accept this cycle
icode  in  4  instruction code
ifun  in  4  function code
val_a  in  WIDTH  operand A
val_b  in  WIDTH  operand B
val_c  in  WIDTH  immediate
dst_e  in  4  destination register id
out_valid  out  1  result register holds an instruction
out_ready  in  1  memory stage accepts
out_val_e  out  WIDTH  registered ALU result
out_cnd  out  1  registered condition result
out_dst_e  out  4  registered destination; 4'hF (RNONE) when cmov is not taken
cc  out  3  {ZF,SF,OF} current CC register

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_val_e=0, out_cnd=0, out_dst_e=4'hF, cc=3'b100.
- in_ready = (!out_valid | out_ready) & !flush. Accept = in_valid & in_ready. Latency is 1 cycle: accepted data appears on the out_* registers at the next edge.
- On accept, the output register loads and out_valid=1. If there is no accept and out_ready=1, out_valid becomes 0. If out_valid=1 and out_ready=0, all out_* hold stable.
- flush has priority. At the edge, out_valid becomes 0, nothing is accepted, and the CC does not change.
- val_e by icode (A=val_a, B=val_b, C=val_c):
  - 0 HALT, 1 NOP: val_e = 0.
  - 2 CMOV: val_e = A.
  - 3 IRMOV: val_e = C.
  - 4 RMMOV, 5 MRMOV: val_e = B+C.
  - 6 OPQ: ifun 0 gives B+A, 1 gives B-A, 2 gives B&A, 3 gives B^A; ifun >3 gives 0.
  - 7 JXX: val_e = 0.
  - 8 CALL, A PUSH: val_e = B-STACK_STEP.
  - 9 RET, B POP: val_e = B+STACK_STEP.
  - Other codes: val_e = 0.
- All arithmetic is modulo 2^WIDTH.
- Flags, computed on the OPQ result only:
  - ZF = (result==0).
  - SF = result[WIDTH-1].
  - ADD: OF = (A and B have the same sign) & (result sign differs from them).
  - SUB: OF = (A and B signs differ) & (result sign != B sign).
  - AND/XOR: OF = 0.
- CC updates at the edge of an accepted OPQ with ifun 0..3. All other instructions leave CC unchanged.
- Condition from ifun, evaluated against the CC register value before any same-cycle update:
  - 0: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - 7..15: 0.
- out_cnd is the condition result for JXX/CMOV and 0 for all other instructions.
- out_dst_e = dst_e, except CMOV with condition 0, which gives 4'hF.
- Back-to-back case: an OPQ accepted in cycle N followed by a JXX accepted in cycle N+1 sees the updated CC.
- Reset asserted mid-transfer discards the held result immediately.

Optional Feature:
CC_INHIBIT_EN.
- Defined: adds input set_cc_inhibit (1 bit). When it is 1 at an accepting edge, the OPQ CC update is suppressed; val_e is still produced.
- Undefined: the port is absent and an accepted OPQ always updates CC.

Decomposition:
- Shared package y86_pkg:
  - icode constants.
  - ALU ifun constants (ADD/SUB/AND/XOR).
  - Condition ifun constants.
  - RNONE=4'hF.
  - CC bit indices ZF=2, SF=1, OF=0.
  - CC reset value 3'b100.
- One natural sub-module, alu_core: combinational, WIDTH-parameterised, inputs a, b, op, outputs result and {ZF,SF,OF}. ex_alu_issue instantiates it once, with operand muxing done outside.

Test Plan:
- Reset release, then OPQ XOR with A=32'h0000000B, B=32'h00000004 -> next cycle out_val_e=32'h0000000F, out_valid=1, cc=3'b000.
- OPQ SUB with A=1, B=32'h80000000 -> out_val_e=32'h7FFFFFFF, cc=3'b001 (OF). A following JXX with ifun=2 (l) -> out_cnd=1.
- OPQ XOR with A=B=32'h00000009 -> val_e=0, cc=3'b100. Next CMOV with ifun=4 (ne), dst_e=3 -> out_cnd=0, out_dst_e=4'hF.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable, no second accept. Release out_ready -> next instruction loads.
- PUSH with B=32'h00000100, then flush asserted in the same cycle as an OPQ ADD -> OPQ not accepted, out_valid=0 after the edge, cc unchanged.
- With CC_INHIBIT_EN: OPQ ADD 32'hFFFFFFFF+1 with set_cc_inhibit=1 -> out_val_e=0, cc keeps its prior value.
